result_monitor: RTL and testbench

//   Self-checking consumer of the CPU external bus, downstream of the core's memory port.

---
 rtl/result_monitor.sv | 104 ++++++++++
 tb/tb_result_monitor.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/result_monitor.sv
// rtl/result_monitor.sv - bus snooper that latches PASS/FAIL/TIMEOUT from writes to one result byte
module result_monitor #(
    parameter logic [15:0] RESULT_ADDR    = 16'h0042,
    parameter logic [7:0]  EXPECT         = 8'hCF,
    parameter int unsigned TIMEOUT_CYCLES = 50,
    parameter int          CNT_W          = 16
) (
    input  logic             ph2,
    input  logic             resetb,
    input  logic             start,
    input  logic [15:0]      address,
    input  logic [7:0]       data_out,
    input  logic             memwrite,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic [7:0]       last_value,
    output logic [7:0]       write_count,
    output logic [CNT_W-1:0] cycles
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
            $error("result_monitor: TIMEOUT_CYCLES must be non-zero");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_PASS,
        S_FAIL,
        S_TIMEOUT
    } state_t;

    state_t state, state_nxt;
    logic   mismatch;
    logic   hit, hit_good, expire;

    assign hit      = memwrite && (address == RESULT_ADDR);
    assign hit_good = hit && (data_out == EXPECT);
    // >= rather than == so a mis-sized counter can never strand the FSM in ARMED
    assign expire   = (cycles >= CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge ph2 or negedge resetb) begin
        if (!resetb) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_ARMED;
            end
            S_ARMED: begin
                if (start) begin
                    state_nxt = S_ARMED;
                end else if (hit_good) begin
                    state_nxt = S_PASS;
                end else if (expire) begin
                    // a wrong write landing on the expiry cycle still counts as a mismatch
                    state_nxt = (mismatch || hit) ? S_FAIL : S_TIMEOUT;
                end
            end
            default: begin
                if (start) state_nxt = S_ARMED;
            end
        endcase
    end

    always_comb begin
        pass    = (state == S_PASS);
        fail    = (state == S_FAIL);
        timeout = (state == S_TIMEOUT);
        done    = pass | fail | timeout;
    end

    always_ff @(posedge ph2 or negedge resetb) begin
        if (!resetb) begin
            cycles      <= '0;
            write_count <= '0;
            last_value  <= '0;
            mismatch    <= 1'b0;
        end else if (start) begin
            cycles      <= '0;
            write_count <= '0;
            last_value  <= '0;
            mismatch    <= 1'b0;
        end else if (state == S_ARMED) begin
            if (cycles != '1) cycles <= cycles + 1'b1;
            if (memwrite && (write_count != 8'hFF)) write_count <= write_count + 8'd1;
            if (hit) begin
                last_value <= data_out;
                if (!hit_good) mismatch <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_result_monitor.sv
// tb/tb_result_monitor.sv - directed table-driven bench for result_monitor
module tb_result_monitor;

    logic        ph2 = 1'b0;
    logic        resetb = 1'b0;
    logic        start = 1'b0;
    logic [15:0] address = '0;
    logic [7:0]  data_out = '0;
    logic        memwrite = 1'b0;

    logic        done, pass, fail, timeout;
    logic [7:0]  last_value, write_count;
    logic [15:0] cycles;
    logic        done_l, pass_l, fail_l, timeout_l;
    logic [7:0]  last_value_l, write_count_l;
    logic [15:0] cycles_l;

    int n_pass = 0;
    int n_total = 0;

    always #5 ph2 = ~ph2;

    result_monitor u_dut (
        .ph2(ph2), .resetb(resetb), .start(start), .address(address),
        .data_out(data_out), .memwrite(memwrite), .done(done), .pass(pass),
        .fail(fail), .timeout(timeout), .last_value(last_value),
        .write_count(write_count), .cycles(cycles)
    );

    result_monitor #(.TIMEOUT_CYCLES(1000)) u_dut_long (
        .ph2(ph2), .resetb(resetb), .start(start), .address(address),
        .data_out(data_out), .memwrite(memwrite), .done(done_l), .pass(pass_l),
        .fail(fail_l), .timeout(timeout_l), .last_value(last_value_l),
        .write_count(write_count_l), .cycles(cycles_l)
    );

    typedef struct {
        logic        s;
        logic        mw;
        logic [15:0] a;
        logic [7:0]  d;
        logic [35:0] exp;
    } vec_t;

    vec_t vecs[11];

    function automatic logic [35:0] obs();
        return {done, pass, fail, timeout, last_value, write_count, cycles};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step(input logic s, input logic mw, input logic [15:0] a, input logic [7:0] d);
        start    = s;
        memwrite = mw;
        address  = a;
        data_out = d;
        @(posedge ph2);
        #1;
    endtask

    task automatic do_reset();
        resetb = 1'b0;
        step(1'b0, 1'b0, 16'h0, 8'h0);
        resetb = 1'b1;
    endtask

    initial begin
        int n;
        // {done,pass,fail,timeout}, last_value, write_count, cycles
        vecs[0]  = '{1'b0, 1'b1, 16'h0042, 8'hCF, {4'b0000, 8'h00, 8'd0, 16'd0}};
        vecs[1]  = '{1'b1, 1'b0, 16'h0000, 8'h00, {4'b0000, 8'h00, 8'd0, 16'd0}};
        vecs[2]  = '{1'b0, 1'b1, 16'h0042, 8'h12, {4'b0000, 8'h12, 8'd1, 16'd1}};
        vecs[3]  = '{1'b0, 1'b1, 16'h0043, 8'hCF, {4'b0000, 8'h12, 8'd2, 16'd2}};
        vecs[4]  = '{1'b0, 1'b0, 16'h0042, 8'hCF, {4'b0000, 8'h12, 8'd2, 16'd3}};
        vecs[5]  = '{1'b0, 1'b1, 16'h0042, 8'hCF, {4'b1100, 8'hCF, 8'd3, 16'd4}};
        vecs[6]  = '{1'b0, 1'b1, 16'h0042, 8'h55, {4'b1100, 8'hCF, 8'd3, 16'd4}};
        vecs[7]  = '{1'b1, 1'b1, 16'h0042, 8'hCF, {4'b0000, 8'h00, 8'd0, 16'd0}};
        vecs[8]  = '{1'b1, 1'b1, 16'h0042, 8'h12, {4'b0000, 8'h00, 8'd0, 16'd0}};
        vecs[9]  = '{1'b0, 1'b1, 16'h0142, 8'hCF, {4'b0000, 8'h00, 8'd1, 16'd1}};
        vecs[10] = '{1'b0, 1'b1, 16'h0042, 8'hCF, {4'b1100, 8'hCF, 8'd2, 16'd2}};

        do_reset();
        check("reset_state", 64'(obs()), 64'd0);

        for (int i = 0; i < 11; i++) begin
            step(vecs[i].s, vecs[i].mw, vecs[i].a, vecs[i].d);
            check($sformatf("vec%0d", i), 64'(obs()), 64'(vecs[i].exp));
        end

        // pass at cycle 10
        do_reset();
        step(1'b1, 1'b0, 16'h0, 8'h0);
        repeat (9) step(1'b0, 1'b0, 16'h0, 8'h0);
        check("t1_before", 64'(obs()), 64'({4'b0000, 8'h00, 8'd0, 16'd9}));
        step(1'b0, 1'b1, 16'h0042, 8'hCF);
        check("t1_pass", 64'(obs()), 64'({4'b1100, 8'hCF, 8'd1, 16'd10}));

        // wrong value only -> FAIL at expiry
        do_reset();
        step(1'b1, 1'b0, 16'h0, 8'h0);
        step(1'b0, 1'b1, 16'h0042, 8'h12);
        n = 1;
        while (!done && n < 100) begin
            step(1'b0, 1'b0, 16'h0, 8'h0);
            n++;
        end
        check("t3_edges", 64'(n), 64'd50);
        check("t3_fail", 64'(obs()), 64'({4'b1010, 8'h12, 8'd1, 16'd50}));
        step(1'b0, 1'b1, 16'h0042, 8'hCF);
        check("t3_sticky", 64'(obs()), 64'({4'b1010, 8'h12, 8'd1, 16'd50}));

        // other addresses only -> TIMEOUT
        do_reset();
        step(1'b1, 1'b0, 16'h0, 8'h0);
        step(1'b0, 1'b1, 16'h0043, 8'hCF);
        step(1'b0, 1'b1, 16'h0142, 8'hCF);
        n = 2;
        while (!done && n < 100) begin
            step(1'b0, 1'b0, 16'h0, 8'h0);
            n++;
        end
        check("t4_edges", 64'(n), 64'd50);
        check("t4_timeout", 64'(obs()), 64'({4'b1001, 8'h00, 8'd2, 16'd50}));

        // correct write on the expiry cycle wins
        do_reset();
        step(1'b1, 1'b0, 16'h0, 8'h0);
        n = 0;
        while (cycles != 16'd49 && n < 100) begin
            step(1'b0, 1'b0, 16'h0, 8'h0);
            n++;
        end
        check("t5_reach49", 64'(n), 64'd49);
        check("t5_not_done", 64'(done), 64'd0);
        step(1'b0, 1'b1, 16'h0042, 8'hCF);
        check("t5_pass", 64'(obs()), 64'({4'b1100, 8'hCF, 8'd1, 16'd50}));

        // async reset mid-ARMED, then no capture without start
        do_reset();
        step(1'b1, 1'b0, 16'h0, 8'h0);
        step(1'b0, 1'b1, 16'h0042, 8'h12);
        repeat (19) step(1'b0, 1'b0, 16'h0, 8'h0);
        check("t6_armed20", 64'(obs()), 64'({4'b0000, 8'h12, 8'd1, 16'd20}));
        #2 resetb = 1'b0;
        #1;
        check("t6_async_rst", 64'(obs()), 64'd0);
        @(negedge ph2);
        resetb = 1'b1;
        step(1'b0, 1'b1, 16'h0042, 8'hCF);
        check("t6_no_start", 64'(obs()), 64'd0);

        // write_count saturation on the long-timeout instance
        step(1'b1, 1'b0, 16'h0, 8'h0);
        repeat (254) step(1'b0, 1'b1, 16'h0010, 8'h00);
        check("t6_wc_254", 64'(write_count_l), 64'hFE);
        repeat (46) step(1'b0, 1'b1, 16'h0010, 8'h00);
        check("t6_wc_sat", 64'(write_count_l), 64'hFF);
        check("t6_long_armed", 64'({done_l, cycles_l}), 64'd300);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
